// File: rtl/rx_cmd_parser.sv
// rx_cmd_parser
// -----------------------------------------------------------------------------
// Purpose:
//   Parses ASCII command frames of the form '$' <letter> [0-2 hex digits] CR
//   from the byte stream of the UART receiver. Each frame produces either one
//   decoded command (cmd_valid pulse) or one error (err pulse).
//
// Ports:
//   clk        in   system clock, all logic on the rising edge
//   rst        in   synchronous reset, active-low
//   rxdone     in   byte-ready level from the receiver (may stay high)
//   datain     in   received byte, valid while rxdone is high
//   cmd_valid  out  one-cycle pulse: cmd_code/cmd_arg/cmd_nargs updated
//   cmd_code   out  uppercase ASCII command letter
//   cmd_arg    out  argument value built from the hex digits
//   cmd_nargs  out  number of hex digits received (0..2)
//   err        out  one-cycle pulse: frame aborted
//   err_code   out  1=bad command letter, 2=bad/excess argument, 3=timeout
//   busy       out  high while a frame is in progress (CMD or ARG)
//
// Parameters:
//   NBITS      byte width of datain (only 8 is supported)
//   TIMEOUT    max clk cycles between bytes inside a frame before abort
// -----------------------------------------------------------------------------
module rx_cmd_parser #(
    parameter int NBITS   = 8,
    parameter int TIMEOUT = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rxdone,
    input  logic [NBITS-1:0] datain,
    output logic             cmd_valid,
    output logic [7:0]       cmd_code,
    output logic [7:0]       cmd_arg,
    output logic [1:0]       cmd_nargs,
    output logic             err,
    output logic [1:0]       err_code,
    output logic             busy
);

    localparam int            CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_CR     = 8'h0D;
    localparam logic [7:0] CH_LF     = 8'h0A;

    localparam logic [1:0] ERR_CMD = 2'd1;
    localparam logic [1:0] ERR_ARG = 2'd2;
    localparam logic [1:0] ERR_TMO = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        ARG  = 2'd2
    } state_t;

    state_t        state_r;
    logic          rxdone_prev_r;
    logic [7:0]    code_acc_r;
    logic [7:0]    arg_acc_r;
    logic [1:0]    nargs_acc_r;
    logic [CW-1:0] tmo_cnt_r;

    logic          byte_ev_s;
    logic [7:0]    byte_s;

    // ASCII classification helpers
    function automatic logic is_digit(input logic [7:0] c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    function automatic logic is_hex(input logic [7:0] c);
        return is_digit(c) ||
               ((c >= 8'h41) && (c <= 8'h46)) ||
               ((c >= 8'h61) && (c <= 8'h66));
    endfunction

    // 'A'/'a' have low nibble 1, so adding 9 yields 10..15 for both cases
    function automatic logic [3:0] hex_val(input logic [7:0] c);
        if (is_digit(c)) begin
            return c[3:0];
        end else begin
            return c[3:0] + 4'd9;
        end
    endfunction

    function automatic logic is_letter(input logic [7:0] c);
        return ((c >= 8'h41) && (c <= 8'h5A)) ||
               ((c >= 8'h61) && (c <= 8'h7A));
    endfunction

    // Lowercase differs from uppercase only in bit 5
    function automatic logic [7:0] to_upper(input logic [7:0] c);
        return c & 8'hDF;
    endfunction

    // Rising edge of rxdone marks a byte; a held-high rxdone yields one event
    always_comb begin
        byte_s    = datain[7:0];
        byte_ev_s = rxdone & ~rxdone_prev_r;
    end

    // Frame FSM, accumulators, timeout counter and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r       <= IDLE;
            rxdone_prev_r <= 1'b1;
            code_acc_r    <= 8'h00;
            arg_acc_r     <= 8'h00;
            nargs_acc_r   <= 2'd0;
            tmo_cnt_r     <= CNT_ZERO;
            cmd_valid     <= 1'b0;
            cmd_code      <= 8'h00;
            cmd_arg       <= 8'h00;
            cmd_nargs     <= 2'd0;
            err           <= 1'b0;
            err_code      <= 2'd0;
            busy          <= 1'b0;
        end else begin
            rxdone_prev_r <= rxdone;
            cmd_valid     <= 1'b0;
            err           <= 1'b0;

            if (byte_ev_s) begin
                // A byte event always wins over a coincident timeout
                tmo_cnt_r <= CNT_ZERO;
                case (state_r)
                    IDLE: begin
                        if (byte_s == CH_DOLLAR) begin
                            state_r <= CMD;
                            busy    <= 1'b1;
                        end
                    end
                    CMD: begin
                        if (is_letter(byte_s)) begin
                            code_acc_r  <= to_upper(byte_s);
                            arg_acc_r   <= 8'h00;
                            nargs_acc_r <= 2'd0;
                            state_r     <= ARG;
                            busy        <= 1'b1;
                        end else if ((byte_s == CH_DOLLAR) || (byte_s == CH_LF)) begin
                            state_r <= CMD;
                        end else begin
                            err      <= 1'b1;
                            err_code <= ERR_CMD;
                            state_r  <= IDLE;
                            busy     <= 1'b0;
                        end
                    end
                    ARG: begin
                        if (is_hex(byte_s)) begin
                            if (nargs_acc_r == 2'd2) begin
                                err      <= 1'b1;
                                err_code <= ERR_ARG;
                                state_r  <= IDLE;
                                busy     <= 1'b0;
                            end else begin
                                arg_acc_r   <= {arg_acc_r[3:0], hex_val(byte_s)};
                                nargs_acc_r <= nargs_acc_r + 2'd1;
                            end
                        end else if (byte_s == CH_CR) begin
                            cmd_valid <= 1'b1;
                            cmd_code  <= code_acc_r;
                            cmd_arg   <= arg_acc_r;
                            cmd_nargs <= nargs_acc_r;
                            state_r   <= IDLE;
                            busy      <= 1'b0;
                        end else if (byte_s == CH_DOLLAR) begin
                            // Resync: restart the frame without reporting an error
                            state_r <= CMD;
                            busy    <= 1'b1;
                        end else if (byte_s == CH_LF) begin
                            state_r <= ARG;
                        end else begin
                            err      <= 1'b1;
                            err_code <= ERR_ARG;
                            state_r  <= IDLE;
                            busy     <= 1'b0;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end else if (state_r != IDLE) begin
                if (tmo_cnt_r == TMO_LAST) begin
                    err       <= 1'b1;
                    err_code  <= ERR_TMO;
                    state_r   <= IDLE;
                    busy      <= 1'b0;
                    tmo_cnt_r <= CNT_ZERO;
                end else begin
                    tmo_cnt_r <= tmo_cnt_r + CNT_ONE;
                end
            end else begin
                tmo_cnt_r <= CNT_ZERO;
            end
        end
    end

endmodule

// File: tb/tb_rx_cmd_parser.sv
// tb_rx_cmd_parser
// -----------------------------------------------------------------------------
// Directed testbench for rx_cmd_parser (instantiated with TIMEOUT=100).
// Inputs are driven on the falling clock edge; outputs are sampled on the
// falling edge, i.e. half a cycle after the rising edge that updates them.
// -----------------------------------------------------------------------------
module tb_rx_cmd_parser;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxdone;
    logic [7:0] datain;
    logic       cmd_valid;
    logic [7:0] cmd_code;
    logic [7:0] cmd_arg;
    logic [1:0] cmd_nargs;
    logic       err;
    logic [1:0] err_code;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int n_valid = 0;
    int n_err = 0;
    int n_both = 0;
    int snap_v;
    int snap_e;

    // Observations one and two cycles after the byte event
    logic pv, pe, pb, pv2, pe2;

    always #5 clk = ~clk;

    rx_cmd_parser #(
        .NBITS   (8),
        .TIMEOUT (100)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rxdone    (rxdone),
        .datain    (datain),
        .cmd_valid (cmd_valid),
        .cmd_code  (cmd_code),
        .cmd_arg   (cmd_arg),
        .cmd_nargs (cmd_nargs),
        .err       (err),
        .err_code  (err_code),
        .busy      (busy)
    );

    // Pulse counters over the whole run
    always @(posedge clk) begin
        if (cmd_valid === 1'b1) n_valid <= n_valid + 1;
        if (err === 1'b1) n_err <= n_err + 1;
        if ((cmd_valid === 1'b1) && (err === 1'b1)) n_both <= n_both + 1;
    end

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Raise rxdone with byte b for 'hold' clocks, then low for 'gap' clocks
    task automatic pulse_byte(input logic [7:0] b, input int hold, input int gap);
        @(negedge clk);
        datain = b;
        rxdone = 1'b1;
        @(negedge clk);
        pv = cmd_valid;
        pe = err;
        pb = busy;
        @(negedge clk);
        pv2 = cmd_valid;
        pe2 = err;
        repeat (hold - 2) @(negedge clk);
        rxdone = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        rst    = 1'b0;
        rxdone = 1'b0;
        datain = 8'h00;
        repeat (3) @(negedge clk);
        check1("rst_cmd_valid", cmd_valid, 1'b0);
        check1("rst_err", err, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check8("rst_cmd_code", cmd_code, 8'h00);
        check8("rst_cmd_arg", cmd_arg, 8'h00);
        check8("rst_cmd_nargs", {6'd0, cmd_nargs}, 8'h00);
        check8("rst_err_code", {6'd0, err_code}, 8'h00);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check1("idle_busy", busy, 1'b0);

        // $B3<CR>
        pulse_byte(8'h24, 3, 10);
        check1("t1_busy_after_dollar", pb, 1'b1);
        pulse_byte(8'h42, 3, 10);
        pulse_byte(8'h33, 3, 10);
        pulse_byte(8'h0D, 3, 10);
        check1("t1_cmd_valid", pv, 1'b1);
        check1("t1_cmd_valid_drop", pv2, 1'b0);
        check8("t1_cmd_code", cmd_code, 8'h42);
        check8("t1_cmd_arg", cmd_arg, 8'h03);
        check8("t1_cmd_nargs", {6'd0, cmd_nargs}, 8'h01);
        check1("t1_busy_after_cr", pb, 1'b0);
        check_int("t1_valid_count", n_valid, 1);
        check_int("t1_err_count", n_err, 0);

        // $w<LF>5a<CR>: lowercase letter and digit, LF ignored
        pulse_byte(8'h24, 3, 10);
        pulse_byte(8'h77, 3, 10);
        pulse_byte(8'h0A, 3, 10);
        check1("t2_busy_after_lf", pb, 1'b1);
        pulse_byte(8'h35, 3, 10);
        pulse_byte(8'h61, 3, 10);
        check1("t2_busy_after_a", pb, 1'b1);
        pulse_byte(8'h0D, 3, 10);
        check1("t2_cmd_valid", pv, 1'b1);
        check1("t2_busy_after_cr", pb, 1'b0);
        check8("t2_cmd_code", cmd_code, 8'h57);
        check8("t2_cmd_arg", cmd_arg, 8'h5A);
        check8("t2_cmd_nargs", {6'd0, cmd_nargs}, 8'h02);

        // $B123<CR>: third digit is an error, CR then ignored
        snap_v = n_valid;
        pulse_byte(8'h24, 3, 10);
        pulse_byte(8'h42, 3, 10);
        pulse_byte(8'h31, 3, 10);
        pulse_byte(8'h32, 3, 10);
        check1("t3_no_err_second_digit", pe, 1'b0);
        pulse_byte(8'h33, 3, 10);
        check1("t3_err", pe, 1'b1);
        check1("t3_err_drop", pe2, 1'b0);
        check1("t3_busy", pb, 1'b0);
        check8("t3_err_code", {6'd0, err_code}, 8'h02);
        pulse_byte(8'h0D, 3, 10);
        check1("t3_cr_ignored", pv, 1'b0);
        check_int("t3_valid_count", n_valid, snap_v);
        check8("t3_cmd_code_held", cmd_code, 8'h57);
        check8("t3_cmd_arg_held", cmd_arg, 8'h5A);
        check8("t3_cmd_nargs_held", {6'd0, cmd_nargs}, 8'h02);

        // $1: bad command letter
        pulse_byte(8'h24, 3, 10);
        pulse_byte(8'h31, 3, 10);
        check1("t4_err", pe, 1'b1);
        check8("t4_err_code", {6'd0, err_code}, 8'h01);

        // $B$S<CR>: resync without error
        snap_e = n_err;
        pulse_byte(8'h24, 3, 10);
        pulse_byte(8'h42, 3, 10);
        pulse_byte(8'h24, 3, 10);
        check1("t5_busy_resync", pb, 1'b1);
        pulse_byte(8'h53, 3, 10);
        pulse_byte(8'h0D, 3, 10);
        check1("t5_cmd_valid", pv, 1'b1);
        check8("t5_cmd_code", cmd_code, 8'h53);
        check8("t5_cmd_arg", cmd_arg, 8'h00);
        check8("t5_cmd_nargs", {6'd0, cmd_nargs}, 8'h00);
        check_int("t5_err_count", n_err, snap_e);
        check8("t5_err_code_held", {6'd0, err_code}, 8'h01);

        // $B then silence: err 100 edges after the B event edge
        pulse_byte(8'h24, 3, 10);
        pulse_byte(8'h42, 3, 0);
        repeat (97) @(negedge clk);
        check1("t6_no_err_edge99", err, 1'b0);
        check1("t6_busy_edge99", busy, 1'b1);
        @(negedge clk);
        check1("t6_err_edge100", err, 1'b1);
        check8("t6_err_code", {6'd0, err_code}, 8'h03);
        check1("t6_busy_drop", busy, 1'b0);
        @(negedge clk);
        check1("t6_err_drop", err, 1'b0);

        // $B then a digit on the last allowed cycle: no timeout
        snap_e = n_err;
        pulse_byte(8'h24, 3, 10);
        pulse_byte(8'h42, 3, 0);
        repeat (96) @(negedge clk);
        pulse_byte(8'h37, 3, 10);
        check1("t7_no_err", pe, 1'b0);
        check1("t7_busy", pb, 1'b1);
        pulse_byte(8'h0D, 3, 10);
        check1("t7_cmd_valid", pv, 1'b1);
        check8("t7_cmd_arg", cmd_arg, 8'h07);
        check8("t7_cmd_nargs", {6'd0, cmd_nargs}, 8'h01);
        check_int("t7_err_count", n_err, snap_e);

        // Reset in ARG with rxdone held high across release
        pulse_byte(8'h24, 3, 10);
        pulse_byte(8'h42, 3, 10);
        @(negedge clk);
        datain = 8'h34;
        rxdone = 1'b1;
        @(negedge clk);
        check1("t8_busy_before_rst", busy, 1'b1);
        snap_e = n_err;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check1("t8_busy", busy, 1'b0);
        check8("t8_cmd_code", cmd_code, 8'h00);
        check8("t8_cmd_arg", cmd_arg, 8'h00);
        check8("t8_err_code", {6'd0, err_code}, 8'h00);
        datain = 8'h24;
        repeat (3) @(negedge clk);
        check1("t8_held_rxdone_no_event", busy, 1'b0);
        check_int("t8_no_err_pulse", n_err, snap_e);
        rxdone = 1'b0;
        @(negedge clk);
        pulse_byte(8'h24, 3, 10);
        check1("t8_busy_after_new_edge", pb, 1'b1);
        pulse_byte(8'h4B, 3, 10);
        pulse_byte(8'h0D, 3, 10);
        check1("t8_cmd_valid", pv, 1'b1);
        check8("t8_cmd_code_k", cmd_code, 8'h4B);
        check8("t8_cmd_nargs_k", {6'd0, cmd_nargs}, 8'h00);

        check_int("never_both_pulses", n_both, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_cmd_parser.md
Name: rx_cmd_parser

Overview:
- Consumes the byte stream produced by the UART receiver (byte plus done flag) and parses ASCII command frames of the form '$' <letter> [0-2 hex digits] CR.
- Emits one decoded command (code, argument, digit count) or one error per frame.
- Sits directly downstream of rx, in parallel with the write-control/RAM path.
- Feeds the control logic (baud select, TX mode) with validated commands.

Parameters:
NBITS, 8, byte width of datain (fixed at 8 for ASCII; other values unsupported).
TIMEOUT, 1000000, max clk cycles allowed between bytes inside a frame before abort.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  synchronous reset, active-low.
rxdone  input  1  byte-ready flag from rx; level, may stay high for many clk cycles.
datain  input  8  received byte; valid while rxdone high.
cmd_valid  output  1  one-cycle pulse: cmd_code/cmd_arg/cmd_nargs updated.
cmd_code  output  8  uppercase ASCII command letter.
cmd_arg  output  8  argument value from hex digits.
cmd_nargs  output  2  number of hex digits received (0..2).
err  output  1  one-cycle pulse: frame aborted.
err_code  output  2  1=bad command letter, 2=bad/excess argument char, 3=timeout.
busy  output  1  high while in CMD or ARG state.

Behaviour:
- Reset (rst=0 at clk edge):
  - state=IDLE; all outputs 0; arg accumulator, digit count and timeout counter 0.
  - rxdone edge register set to 1, so rxdone held high across reset release does not produce a byte.
- Byte event:
  - Occurs in cycle N when rxdone=1 and the previous-cycle sample=0.
  - datain is captured in cycle N and the FSM updates at the end of N.
  - Result pulses (cmd_valid or err) are high in cycle N+1 only.
- States:
  - IDLE:
    - '$' -> CMD.
    - Any other byte is ignored.
  - CMD:
    - 'A'-'Z' or 'a'-'z' -> store the uppercase letter, arg=0, nargs=0 -> ARG.
    - '$' -> stay in CMD (resync).
    - 0x0A is ignored.
    - Anything else -> err, err_code=1 -> IDLE.
  - ARG:
    - Hex digit ('0'-'9', 'A'-'F', 'a'-'f') with nargs<2 -> arg={arg[3:0],nibble}, nargs+1.
    - Hex digit with nargs=2 -> err, code 2 -> IDLE.
    - CR (0x0D) -> cmd_valid, with cmd_code/cmd_arg/cmd_nargs loaded from the accumulators -> IDLE.
    - '$' -> CMD (resync, no error).
    - 0x0A is ignored.
    - Any other byte -> err, code 2 -> IDLE.
- Hold rules:
  - cmd_code/cmd_arg/cmd_nargs hold their value until the next cmd_valid.
  - err_code holds until the next err.
  - Neither err nor an abort clears the cmd_* outputs.
- Timeout:
  - Counter clears on every byte event and increments each cycle while busy.
  - When it reaches TIMEOUT-1 with no byte event that cycle: err, code 3 -> IDLE.
  - If a byte event and the timeout fall on the same cycle, the byte event wins and the counter clears.
  - The counter is held at 0 in IDLE.
- busy=1 exactly when state is CMD or ARG (registered, same cycle as the state).
- cmd_valid and err are never high in the same cycle.
- Next byte event: accepted in cycle N+1 if rxdone has toggled low then high.
- Leaving rxdone high forever produces exactly one byte event.
- Reset mid-frame: the frame is discarded, no err pulse, and the module returns to IDLE.

Test Plan:
- Bytes '$','B','3',0x0D (rxdone pulses of 3 clk, 10-clk gaps) -> single cmd_valid pulse one cycle after the CR event; cmd_code=0x42, cmd_arg=0x03, cmd_nargs=1; err never high.
- '$','w','5','a',0x0D -> cmd_code=0x57, cmd_arg=0x5A, cmd_nargs=2; busy high from the '$' event+1 until the CR event+1.
- '$','B','1','2','3',0x0D -> err=1, err_code=2 the cycle after the '3' event; CR ignored; no cmd_valid; cmd_* keep their previous values.
- '$','1' -> err_code=1. Separately, with TIMEOUT=100: '$','B' then silence -> err_code=3 exactly 100 cycles after the 'B' event; busy drops with it. A byte arriving on cycle 99 prevents the timeout.
- '$','B','$','S',0x0D -> no err; cmd_code=0x53, cmd_nargs=0, cmd_arg=0.
- rst=0 during ARG with rxdone held high through reset release -> all outputs 0, state IDLE, no byte event until rxdone falls and rises again.
